led_seq_ctrl: RTL

Sequencer for the 8-LED board output. It generates a programmable step tick and walks the LED register through one of four patterns. Three single-cycle key pulses control it: mode select, speed select and pause. It sits between the key front-end (debounce and edge-detect pulse outputs) and the LED pins.

---
 rtl/led_pkg.sv | 32 +++
 rtl/led_tick_gen.sv | 46 ++++
 rtl/led_seq_ctrl.sv | 116 +++++++++++
 3 files changed

// File: rtl/led_pkg.sv
// Shared encodings and helpers for the LED sequencer.
package led_pkg;

   typedef enum logic [1:0] {
      MODE_RUN_R  = 2'd0,
      MODE_RUN_L  = 2'd1,
      MODE_BOUNCE = 2'd2,
      MODE_FILL   = 2'd3
   } mode_e;

   typedef enum logic {
      DIR_LEFT  = 1'b0,
      DIR_RIGHT = 1'b1
   } dir_e;

   localparam logic [7:0] SEED_ONEHOT = 8'h01;
   localparam logic [7:0] SEED_FILL   = 8'h00;

   // Pattern a mode starts from.
   function automatic logic [7:0] mode_seed(input mode_e mode);
      return (mode == MODE_FILL) ? SEED_FILL : SEED_ONEHOT;
   endfunction

   // One-hot for the walking modes, thermometer code for FILL.
   function automatic logic led_legal(input mode_e mode, input logic [7:0] led);
      if (mode == MODE_FILL) begin
         return (led & (led + 8'd1)) == 8'd0;
      end
      return (led != 8'd0) && ((led & (led - 8'd1)) == 8'd0);
   endfunction

endpackage

// File: rtl/led_tick_gen.sv
// Step counter: divides CLK by T_STEP >> speed, freezes while paused.
module led_tick_gen #(
   parameter int unsigned T_STEP = 50000000,
   parameter int unsigned CNT_W  = 26
) (
   input  logic       CLK,
   input  logic       RSTn,
   input  logic [1:0] speed_i,
   input  logic       paused_i,
   input  logic       clr_i,
   output logic       step_o
);

   logic [CNT_W-1:0] count_q, count_d;
   logic [CNT_W-1:0] period_m1;

   // Terminal count for the current speed, and the step strobe.
   always_comb begin
      period_m1 = CNT_W'((T_STEP >> speed_i) - 32'd1);
      step_o    = !paused_i && (count_q == period_m1);
   end

   // Clear wins over everything; pause holds the count mid-period.
   always_comb begin
      count_d = count_q;
      if (clr_i) begin
         count_d = '0;
      end else if (paused_i) begin
         count_d = count_q;
      end else if (step_o) begin
         count_d = '0;
      end else begin
         count_d = count_q + CNT_W'(1);
      end
   end

   // Counter register.
   always_ff @(posedge CLK or negedge RSTn) begin
      if (!RSTn) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

endmodule

// File: rtl/led_seq_ctrl.sv
// LED pattern sequencer: mode/speed/pause registers and pattern stepping.
module led_seq_ctrl
   import led_pkg::*;
#(
   parameter int unsigned T_STEP = 50000000,
   parameter int unsigned CNT_W  = 26
) (
   input  logic       CLK,
   input  logic       RSTn,
   input  logic       Mode_Key,
   input  logic       Speed_Key,
   input  logic       Pause_Key,
   output logic [7:0] LED_Out,
   output logic [1:0] Mode,
   output logic [1:0] Speed,
   output logic       Paused,
   output logic       Step_Tick
);

   logic [7:0] led_q, led_d;
   mode_e      mode_q, mode_d;
   logic [1:0] speed_q, speed_d;
   logic       paused_q, paused_d;
   dir_e       dir_q, dir_d;
   logic       tick_q, tick_d;

   logic [7:0] pat_next;
   dir_e       dir_next;
   logic       step;

   led_tick_gen #(
      .T_STEP (T_STEP),
      .CNT_W  (CNT_W)
   ) u_tick_gen (
      .CLK      (CLK),
      .RSTn     (RSTn),
      .speed_i  (speed_q),
      .paused_i (paused_q),
      .clr_i    (Mode_Key | Speed_Key),
      .step_o   (step)
   );

   // Next pattern for the current mode; an illegal pattern falls back to the seed.
   always_comb begin
      pat_next = led_q;
      dir_next = dir_q;
      if (!led_legal(mode_q, led_q)) begin
         pat_next = mode_seed(mode_q);
         dir_next = DIR_LEFT;
      end else begin
         unique case (mode_q)
            MODE_RUN_R: pat_next = {led_q[0], led_q[7:1]};
            MODE_RUN_L: pat_next = {led_q[6:0], led_q[7]};
            MODE_BOUNCE: begin
               if (dir_q == DIR_LEFT) begin
                  pat_next = {led_q[6:0], 1'b0};
                  if (pat_next == 8'h80) dir_next = DIR_RIGHT;
               end else begin
                  pat_next = {1'b0, led_q[7:1]};
                  if (pat_next == 8'h01) dir_next = DIR_LEFT;
               end
            end
            MODE_FILL: pat_next = (led_q == 8'hFF) ? 8'h00 : {led_q[6:0], 1'b1};
         endcase
      end
   end

   // Key handling; a mode change discards a coincident step.
   always_comb begin
      led_d    = led_q;
      mode_d   = mode_q;
      speed_d  = speed_q;
      paused_d = paused_q;
      dir_d    = dir_q;
      tick_d   = 1'b0;
      if (step) begin
         led_d  = pat_next;
         dir_d  = dir_next;
         tick_d = 1'b1;
      end
      if (Mode_Key) begin
         mode_d = mode_e'(mode_q + 2'd1);
         led_d  = mode_seed(mode_d);
         dir_d  = DIR_LEFT;
         tick_d = 1'b0;
      end
      if (Speed_Key) speed_d = speed_q + 2'd1;
      if (Pause_Key) paused_d = ~paused_q;
   end

   // Control and output registers.
   always_ff @(posedge CLK or negedge RSTn) begin
      if (!RSTn) begin
         led_q    <= SEED_ONEHOT;
         mode_q   <= MODE_RUN_R;
         speed_q  <= 2'd0;
         paused_q <= 1'b0;
         dir_q    <= DIR_LEFT;
         tick_q   <= 1'b0;
      end else begin
         led_q    <= led_d;
         mode_q   <= mode_d;
         speed_q  <= speed_d;
         paused_q <= paused_d;
         dir_q    <= dir_d;
         tick_q   <= tick_d;
      end
   end

   assign LED_Out   = led_q;
   assign Mode      = mode_q;
   assign Speed     = speed_q;
   assign Paused    = paused_q;
   assign Step_Tick = tick_q;

endmodule
